// File: rtl/move_dispatch.sv
// move_dispatch: scans a 64-square board for a piece code and drives the move generator once per match,
// packing the generated boards contiguously at the destination.
module move_dispatch (
   input  logic        clk,
   input  logic        rst,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   input  logic        bm_waitrequest,
   output logic [31:0] bm_address,
   output logic        bm_read,
   input  logic [31:0] bm_readdata,
   input  logic        bm_readdatavalid,
   input  logic        gm_waitrequest,
   output logic [3:0]  gm_address,
   output logic        gm_read,
   input  logic [31:0] gm_readdata,
   output logic        gm_write,
   output logic [31:0] gm_writedata
);
   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, CHECK, W_SRC, W_DEST, W_X, W_Y, W_GO, R_CNT, ADVANCE, NEXT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] total_q, total_d;
   logic [5:0]  sq_q, sq_d;
   logic [31:0] src_q, src_d, dest_q, dest_d, dcur_q, dcur_d;
   logic [7:0]  code_q, code_d, byte_q, byte_d, cnt_q, cnt_d;
   logic        bm_read_q, bm_read_d, gm_read_q, gm_read_d, gm_write_q, gm_write_d;
   logic [31:0] bm_address_q, bm_address_d, gm_writedata_q, gm_writedata_d;
   logic [3:0]  gm_address_q, gm_address_d;
   logic        busy;
   logic        unused;

   assign busy              = state_q != IDLE;
   assign slave_waitrequest = 1'b0;
   assign slave_readdata    = slave_address == 4'd0 ? {busy, 15'd0, total_q} : 32'd0;
   assign bm_read           = bm_read_q;
   assign bm_address        = bm_address_q;
   assign gm_read           = gm_read_q;
   assign gm_write          = gm_write_q;
   assign gm_address        = gm_address_q;
   assign gm_writedata      = gm_writedata_q;
   assign unused            = ^{slave_read, bm_readdata[31:8], gm_readdata[31:8]};

   always_comb begin
      state_d = state_q;
      total_d = total_q;
      sq_d    = sq_q;
      src_d   = src_q;
      dest_d  = dest_q;
      code_d  = code_q;
      dcur_d  = dcur_q;
      byte_d  = byte_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (slave_write) begin
            src_d  = slave_address == 4'd1 ? slave_writedata : src_q;
            dest_d = slave_address == 4'd2 ? slave_writedata : dest_q;
            code_d = slave_address == 4'd3 ? slave_writedata[7:0] : code_q;
            if (slave_address == 4'd0) begin
               total_d = '0;
               sq_d    = '0;
               dcur_d  = dest_q;
               state_d = RD_REQ;
            end
         end
         RD_REQ:  state_d = bm_waitrequest ? RD_REQ : RD_WAIT;
         RD_WAIT: if (bm_readdatavalid) begin
            byte_d  = bm_readdata[7:0];
            state_d = CHECK;
         end
         CHECK:   state_d = (byte_q == code_q && code_q != 8'd0) ? W_SRC : NEXT;
         W_SRC:   state_d = gm_waitrequest ? W_SRC : W_DEST;
         W_DEST:  state_d = gm_waitrequest ? W_DEST : W_X;
         W_X:     state_d = gm_waitrequest ? W_X : W_Y;
         W_Y:     state_d = gm_waitrequest ? W_Y : W_GO;
         W_GO:    state_d = gm_waitrequest ? W_GO : R_CNT;
         R_CNT: if (!gm_waitrequest) begin
            cnt_d   = gm_readdata[7:0];
            state_d = ADVANCE;
         end
         ADVANCE: begin
            total_d = total_q + {8'd0, cnt_q};
            dcur_d  = dcur_q + {16'd0, cnt_q, 8'd0};
            state_d = NEXT;
         end
         NEXT: begin
            sq_d    = sq_q + 6'd1;
            state_d = sq_q == 6'd63 ? IDLE : RD_REQ;
         end
         default: state_d = IDLE;
      endcase
      // Bus outputs are registered, so they are computed from the state being entered.
      bm_read_d      = state_d == RD_REQ;
      bm_address_d   = bm_read_d ? src_d + {24'd0, sq_d, 2'b00} : 32'd0;
      gm_write_d     = state_d inside {W_SRC, W_DEST, W_X, W_Y, W_GO};
      gm_read_d      = state_d == R_CNT;
      gm_address_d   = state_d == W_SRC  ? 4'd1 :
                       state_d == W_DEST ? 4'd2 :
                       state_d == W_X    ? 4'd3 :
                       state_d == W_Y    ? 4'd4 : 4'd0;
      gm_writedata_d = state_d == W_SRC  ? src_q :
                       state_d == W_DEST ? dcur_q :
                       state_d == W_X    ? {29'd0, sq_q[2:0]} :
                       state_d == W_Y    ? {29'd0, sq_q[5:3]} : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         total_q        <= '0;
         sq_q           <= '0;
         src_q          <= '0;
         dest_q         <= '0;
         code_q         <= '0;
         dcur_q         <= '0;
         byte_q         <= '0;
         cnt_q          <= '0;
         bm_read_q      <= 1'b0;
         bm_address_q   <= '0;
         gm_read_q      <= 1'b0;
         gm_write_q     <= 1'b0;
         gm_address_q   <= '0;
         gm_writedata_q <= '0;
      end else begin
         state_q        <= state_d;
         total_q        <= total_d;
         sq_q           <= sq_d;
         src_q          <= src_d;
         dest_q         <= dest_d;
         code_q         <= code_d;
         dcur_q         <= dcur_d;
         byte_q         <= byte_d;
         cnt_q          <= cnt_d;
         bm_read_q      <= bm_read_d;
         bm_address_q   <= bm_address_d;
         gm_read_q      <= gm_read_d;
         gm_write_q     <= gm_write_d;
         gm_address_q   <= gm_address_d;
         gm_writedata_q <= gm_writedata_d;
      end
   end
endmodule

// File: doc/move_dispatch.md
# move_dispatch

Hardware board scanner that sits between the HPS/Nios CPU and one piece move-generator accelerator. It reads a 64-square board from SDRAM and finds every square holding a configured piece code. For each match it drives the generator's Avalon-MM slave port: it writes the board arguments, issues go, and reads back the boards-generated count. It packs all generated boards contiguously at the destination and reports the total to the CPU.

## Interface
Parameters: none.

Ports. Reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- slave_waitrequest  out  1  CPU-facing stall; held 0 (register port never stalls)
- slave_address  in  4  CPU register select
- slave_read  in  1  CPU read strobe
- slave_readdata  out  32  {busy, 15'b0, total[15:0]} for address 0; 0 for any other address
- slave_write  in  1  CPU write strobe
- slave_writedata  in  32  CPU write data
- bm_waitrequest  in  1  SDRAM read stall
- bm_address  out  32  SDRAM byte address
- bm_read  out  1  SDRAM read request
- bm_readdata  in  32  SDRAM read data
- bm_readdatavalid  in  1  SDRAM read data valid
- gm_waitrequest  in  1  generator slave stall
- gm_address  out  4  generator word register index
- gm_read  out  1  generator read request
- gm_readdata  in  32  generator count, valid in the cycle the read is accepted
- gm_write  out  1  generator write request
- gm_writedata  out  32  generator write data

## Operation
CPU registers. Writes are ignored while busy.
- Address 1: src board base.
- Address 2: dest base.
- Address 3: piece code (signed, low 8 bits).
- Address 0: start. Sets busy, clears total, sets sq=0, and sets dcur=dest.

Piece code 0 behaviour:
- Every square is still read.
- Nothing matches, so the scan finishes with total=0.

State machine: IDLE → RD_REQ → RD_WAIT → CHECK → {W_SRC → W_DEST → W_X → W_Y → W_GO → R_CNT → ADVANCE} → NEXT → (RD_REQ | IDLE).
- RD_REQ:
  - Drives bm_read=1 and bm_address=src+4*sq.
  - Holds both while bm_waitrequest=1.
  - Moves to RD_WAIT on the first cycle bm_waitrequest=0.
  - Exactly one outstanding read at a time.
- RD_WAIT: latches bm_readdata[7:0] on bm_readdatavalid.
- CHECK:
  - Match when the latched byte equals the code and the code is nonzero.
  - On a match go to W_SRC; otherwise go to NEXT.
- Generator register writes, in order:
  - W_SRC writes index 1 = src.
  - W_DEST writes index 2 = dcur.
  - W_X writes index 3 = sq[2:0].
  - W_Y writes index 4 = sq[5:3].
  - W_GO writes index 0 = 0.
- Each W_* state holds gm_write, gm_address and gm_writedata stable until a cycle with gm_waitrequest=0 (accept), then advances.
- W_GO: the generator holds waitrequest for its entire run; the block simply waits.
- R_CNT:
  - Drives gm_read=1 with gm_address=0.
  - On the accept cycle, captures cnt=gm_readdata[7:0].
- ADVANCE: total += cnt; dcur += cnt<<8 (64 squares × 4 bytes per board).
- NEXT: if sq==63, clear busy and go to IDLE; else sq++ and go to RD_REQ.
- Arithmetic widths:
  - total is 16-bit and wraps (never reached in legal chess).
  - dcur is 32-bit and wraps.
  - sq is 6-bit internally.

## Timing
- Reset values:
  - All requests (bm_read, gm_read, gm_write) are 0.
  - bm_address, gm_address and gm_writedata are 0.
  - slave_waitrequest=0; busy=0; total=0; state=IDLE.
- Reset mid-scan:
  - Everything returns to reset values on the next edge, regardless of pending waitrequest or readdatavalid.
  - A late readdatavalid arriving in IDLE is ignored.
- Latency:
  - Non-matching square: 4 cycles with zero waits.
  - Matching square: 11 cycles plus generator run time plus all stall cycles.
- Request signals never deassert while their waitrequest is high.
- Only one of bm_read, gm_read, gm_write is high in any cycle.
- A CPU read at address 0 returns the current register contents with no stall. Busy reads 1 from the cycle after start until the cycle after NEXT on square 63.
- Start written while busy is ignored; the scan continues unaffected.

## Test plan
- Empty board, code=2, no stalls:
  - Exactly 64 SDRAM reads at src, src+4, …, src+252.
  - No generator writes.
  - Busy drops; status reads 0x0000_0000.
- Single match at square 0 (x=0, y=0), generator returns 14 after 100 stall cycles:
  - Writes 1=src, 2=dest, 3=0, 4=0, 0=0 in that order.
  - Total reads 14.
- Matches at squares 0 and 7 returning 14 and 10:
  - Second dest write = dest+14*256 = dest+0xE00.
  - Final status reads 0x0000_0018 (24).
- Random bm_waitrequest/gm_waitrequest stalls and readdatavalid delays of 0–5 cycles:
  - Address, data and request stay stable through every stall.
  - Result matches the no-stall run.
- Assert rst during W_GO with gm_waitrequest high:
  - Next cycle all requests are 0 and status reads 0.
  - A new start then scans correctly.
- Write code=-2 to address 3 mid-scan:
  - Ignored; matching continues on the original code.
